// File: rtl/sm83_alu_pkg.sv
// Shared types and the flag/result finishing function for the SM83 nibble-serial ALU.
// Included by sm83_alu_slice and sm83_alu_nibble_core.
package sm83_alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int WORD_SIZE = 2 * ALU_WIDTH;

  typedef logic [ALU_WIDTH-1:0] hword_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } alu_state_t;

  typedef struct packed {
    word_t res;
    logic  z;
    logic  n;
    logic  h;
    logic  c;
  } alu_out_t;

  function automatic logic op_is_sub(input alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SBC) || (op == ALU_CP);
  endfunction

  // Turns the raw slice sum and nibble carries into the architectural result and flags.
  // Shifts override the op; shift_l has priority over shift_r.
  function automatic alu_out_t alu_finish(input alu_op_t op, input logic daa, input logic shl,
                                          input logic shr, input logic sin, input word_t a,
                                          input word_t sum, input logic h, input logic c,
                                          input logic pc);
    alu_out_t o;
    o.res = sum;
    o.n   = op_is_sub(op);
    o.h   = h;
    o.c   = c;
    o.z   = 1'b0;
    case (op)
      ALU_AND:         begin o.h = 1'b1; o.c = 1'b0; end
      ALU_XOR, ALU_OR: begin o.h = 1'b0; o.c = 1'b0; end
      default:         ;
    endcase
    if (daa) begin
      o.h = 1'b0;
      o.c = pc | c;
    end
    if (shl) begin
      o.res = {a[WORD_SIZE-2:0], sin};
      o.n   = 1'b0;
      o.h   = 1'b0;
      o.c   = a[WORD_SIZE-1];
    end else if (shr) begin
      o.res = {sin, a[WORD_SIZE-1:1]};
      o.n   = 1'b0;
      o.h   = 1'b0;
      o.c   = a[0];
    end
    o.z = (o.res == '0);
    if ((op == ALU_CP) && !shl && !shr) o.res = a;
    return o;
  endfunction

endpackage

// File: rtl/sm83_alu_slice.sv
// Combinational 4-bit ALU slice. For subtract-type ops cin/cout are borrows:
// the slice adds ~b with the carry-in inverted and reports the inverted carry-out.
module sm83_alu_slice
  import sm83_alu_pkg::*;
(
  input  alu_op_t op,
  input  hword_t  a,
  input  hword_t  b,
  input  logic    cin,
  output hword_t  r,
  output logic    cout
);

  logic [ALU_WIDTH:0] sum;

  always_comb begin
    sum  = '0;
    r    = '0;
    cout = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: begin
        sum  = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, cin};
        r    = sum[ALU_WIDTH-1:0];
        cout = sum[ALU_WIDTH];
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        sum  = {1'b0, a} + {1'b0, ~b} + {{ALU_WIDTH{1'b0}}, ~cin};
        r    = sum[ALU_WIDTH-1:0];
        cout = ~sum[ALU_WIDTH];
      end
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/sm83_alu_nibble_core.sv
// Nibble-serial SM83 ALU datapath with its operand, result and carry buffers.
// Define SM83_ALU_FAST_EN for a single-cycle 8-bit pass built from two chained slices.
module sm83_alu_nibble_core
  import sm83_alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       shift_l,
  input  logic       shift_r,
  input  logic       shift_into_alu,
  input  logic       daa_add,
  input  logic [7:0] daa_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c,
  output logic       pri_carry,
  output logic       daa_carry,
  output logic       shift_dbh,
  output logic       shift_dbl,
  output logic       daa_l_gt_9,
  output logic       daa_h_gt_9,
  output logic       daa_h_eq_9
);

  alu_state_t state_q, state_d;
  word_t      a_q, a_d;
  alu_out_t   out_q, out_d, fin;
  logic       done_q, done_d;
  logic       pri_carry_q, pri_carry_d;
  logic       daa_carry_q, daa_carry_d;

  alu_op_t    in_op, eff_op;
  word_t      eff_b;
  logic       eff_cin;

  // DAA swaps the operand for the correction constant; carry-in only comes from ADC/SBC.
  always_comb begin
    in_op   = alu_op_t'(op);
    eff_op  = in_op;
    eff_b   = b_in;
    eff_cin = 1'b0;
    if (daa_add) begin
      eff_op = (in_op == ALU_SUB) ? ALU_SUB : ALU_ADD;
      eff_b  = daa_out;
    end else if ((in_op == ALU_ADC) || (in_op == ALU_SBC)) begin
      eff_cin = pri_carry_q;
    end
  end

`ifdef SM83_ALU_FAST_EN

  hword_t lo_r, hi_r;
  logic   lo_cout, hi_cout;

  sm83_alu_slice u_slice_lo (
    .op(eff_op), .a(a_in[ALU_WIDTH-1:0]), .b(eff_b[ALU_WIDTH-1:0]),
    .cin(eff_cin), .r(lo_r), .cout(lo_cout)
  );

  sm83_alu_slice u_slice_hi (
    .op(eff_op), .a(a_in[WORD_SIZE-1:ALU_WIDTH]), .b(eff_b[WORD_SIZE-1:ALU_WIDTH]),
    .cin(lo_cout), .r(hi_r), .cout(hi_cout)
  );

  always_comb begin
    state_d     = IDLE;
    a_d         = a_q;
    out_d       = out_q;
    done_d      = 1'b0;
    pri_carry_d = pri_carry_q;
    daa_carry_d = daa_carry_q;
    fin = alu_finish(eff_op, daa_add, shift_l, shift_r, shift_into_alu, a_in,
                     {hi_r, lo_r}, lo_cout, hi_cout, pri_carry_q);
    if (start) begin
      a_d         = a_in;
      out_d       = fin;
      done_d      = 1'b1;
      pri_carry_d = fin.c;
      daa_carry_d = fin.h;
    end
  end

`else

  alu_state_t phase;
  alu_op_t    op_q, op_d, slice_op;
  word_t      b_q, b_d;
  logic       shl_q, shl_d, shr_q, shr_d, sin_q, sin_d, daa_q, daa_d;
  hword_t     lo_q, lo_d, slice_a, slice_b, slice_r;
  logic       hc_q, hc_d, slice_cin, slice_cout;

  // The LO pass runs in the accept cycle straight from the ports so done lands two cycles after start.
  always_comb begin
    phase = (state_q == HI) ? HI : LO;
    if (phase == HI) begin
      slice_op  = op_q;
      slice_a   = a_q[WORD_SIZE-1:ALU_WIDTH];
      slice_b   = b_q[WORD_SIZE-1:ALU_WIDTH];
      slice_cin = hc_q;
    end else begin
      slice_op  = eff_op;
      slice_a   = a_in[ALU_WIDTH-1:0];
      slice_b   = eff_b[ALU_WIDTH-1:0];
      slice_cin = eff_cin;
    end
  end

  sm83_alu_slice u_slice (
    .op(slice_op), .a(slice_a), .b(slice_b), .cin(slice_cin),
    .r(slice_r), .cout(slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    shl_d       = shl_q;
    shr_d       = shr_q;
    sin_d       = sin_q;
    daa_d       = daa_q;
    lo_d        = lo_q;
    hc_d        = hc_q;
    out_d       = out_q;
    done_d      = 1'b0;
    pri_carry_d = pri_carry_q;
    daa_carry_d = daa_carry_q;
    fin = alu_finish(op_q, daa_q, shl_q, shr_q, sin_q, a_q, {slice_r, lo_q},
                     hc_q, slice_cout, pri_carry_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = eff_b;
          op_d    = eff_op;
          shl_d   = shift_l;
          shr_d   = shift_r;
          sin_d   = shift_into_alu;
          daa_d   = daa_add;
          lo_d    = slice_r;
          hc_d    = slice_cout;
          state_d = HI;
        end
      end
      HI: begin
        out_d       = fin;
        done_d      = 1'b1;
        pri_carry_d = fin.c;
        daa_carry_d = fin.h;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_q   <= '0;
      op_q  <= ALU_ADD;
      shl_q <= 1'b0;
      shr_q <= 1'b0;
      sin_q <= 1'b0;
      daa_q <= 1'b0;
      lo_q  <= '0;
      hc_q  <= 1'b0;
    end else begin
      b_q   <= b_d;
      op_q  <= op_d;
      shl_q <= shl_d;
      shr_q <= shr_d;
      sin_q <= sin_d;
      daa_q <= daa_d;
      lo_q  <= lo_d;
      hc_q  <= hc_d;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
      pri_carry_q <= 1'b0;
      daa_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      out_q       <= out_d;
      done_q      <= done_d;
      pri_carry_q <= pri_carry_d;
      daa_carry_q <= daa_carry_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign result     = out_q.res;
  assign flag_z     = out_q.z;
  assign flag_n     = out_q.n;
  assign flag_h     = out_q.h;
  assign flag_c     = out_q.c;
  assign pri_carry  = pri_carry_q;
  assign daa_carry  = daa_carry_q;
  assign shift_dbh  = a_q[WORD_SIZE-1];
  assign shift_dbl  = a_q[0];
  assign daa_l_gt_9 = (a_q[ALU_WIDTH-1:0] > 4'd9);
  assign daa_h_gt_9 = (a_q[WORD_SIZE-1:ALU_WIDTH] > 4'd9);
  assign daa_h_eq_9 = (a_q[WORD_SIZE-1:ALU_WIDTH] == 4'd9);

endmodule

// File: tb/tb_sm83_alu_nibble_core.sv
// Self-checking bench for sm83_alu_nibble_core: directed cases plus randomized ops
// compared against an integer-arithmetic reference model.
module tb_sm83_alu_nibble_core;

  localparam int T_ADD = 0, T_ADC = 1, T_SUB = 2, T_SBC = 3;
  localparam int T_AND = 4, T_XOR = 5, T_OR = 6, T_CP = 7;
`ifdef SM83_ALU_FAST_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, start, shift_l, shift_r, shift_into_alu, daa_add;
  logic [2:0] op;
  logic [7:0] a_in, b_in, daa_out;
  logic       busy, done, flag_z, flag_n, flag_h, flag_c, pri_carry, daa_carry;
  logic       shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  bit m_pc, m_dc;

  typedef struct {
    int res;
    bit z, n, h, c;
  } exp_t;

  sm83_alu_nibble_core dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .shift_l(shift_l), .shift_r(shift_r), .shift_into_alu(shift_into_alu),
    .daa_add(daa_add), .daa_out(daa_out), .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c),
    .pri_carry(pri_carry), .daa_carry(daa_carry), .shift_dbh(shift_dbh),
    .shift_dbl(shift_dbl), .daa_l_gt_9(daa_l_gt_9), .daa_h_gt_9(daa_h_gt_9),
    .daa_h_eq_9(daa_h_eq_9)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t ref_model(int opc, int a, int b, bit shl, bit shr, bit sin,
                                     bit daa, int dout, bit pc);
    exp_t e;
    int bb, cin, full, half;
    bit sub;
    e.res = 0; e.n = 0; e.h = 0; e.c = 0;
    if (shl) begin
      e.res = (a * 2 + int'(sin)) % 256;
      e.c   = (a >= 128);
    end else if (shr) begin
      e.res = int'(sin) * 128 + a / 2;
      e.c   = ((a % 2) == 1);
    end else begin
      bb  = daa ? dout : b;
      cin = (!daa && (opc == T_ADC || opc == T_SBC)) ? int'(pc) : 0;
      sub = daa ? (opc == T_SUB) : (opc == T_SUB || opc == T_SBC || opc == T_CP);
      if (!daa && opc == T_AND) begin
        e.res = a & bb; e.h = 1;
      end else if (!daa && opc == T_XOR) begin
        e.res = a ^ bb;
      end else if (!daa && opc == T_OR) begin
        e.res = a | bb;
      end else if (sub) begin
        full  = a - bb - cin;
        half  = (a % 16) - (bb % 16) - cin;
        e.res = (full + 256) % 256;
        e.c   = (full < 0);
        e.h   = (half < 0);
        e.n   = 1;
      end else begin
        full  = a + bb + cin;
        half  = (a % 16) + (bb % 16) + cin;
        e.res = full % 256;
        e.c   = (full > 255);
        e.h   = (half > 15);
      end
      if (daa) begin
        e.h = 0;
        e.c = pc | e.c;
      end
    end
    e.z = (e.res == 0);
    if (!shl && !shr && !daa && opc == T_CP) e.res = a;
    return e;
  endfunction

  // Drives one op and waits (bounded) for done; lat = edges after the sampling edge.
  task automatic run_op(input int opc, input int a, input int b, input bit shl, input bit shr,
                        input bit sin, input bit daa, input int dout, output int lat);
    @(negedge clk);
    op = 3'(opc); a_in = 8'(a); b_in = 8'(b);
    shift_l = shl; shift_r = shr; shift_into_alu = sin;
    daa_add = daa; daa_out = 8'(dout);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, flag_z, flag_n, flag_h, flag_c, pri_carry, daa_carry} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {busy, done, result, flag_z, flag_n, flag_h, flag_c, pri_carry, daa_carry});
    end
    checks++;
    if ({shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_operand: got %b required 00000",
               {shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9});
    end
    @(negedge clk);
    reset = 1'b0;
    m_pc = 0; m_dc = 0;
  endtask

  task automatic test_directed();
    int lat;
    run_op(T_ADD, 'h3A, 'hC6, 0, 0, 0, 0, 0, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("[TB] FAIL add_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if ({result, flag_z, flag_n, flag_h, flag_c, pri_carry} !== {8'h00, 4'b1011, 1'b1}) begin
      errors++;
      $display("[TB] FAIL add_3a_c6: got res=%h znhc=%b pc=%b required res=00 znhc=1011 pc=1",
               result, {flag_z, flag_n, flag_h, flag_c}, pri_carry);
    end
    run_op(T_ADD, 'h15, 'h27, 0, 0, 0, 0, 0, lat);
    checks++;
    if (result !== 8'h3C) begin errors++; $display("[TB] FAIL add_15_27: got %h required 3c", result); end
    run_op(T_ADD, 'h3C, 'h00, 0, 0, 0, 1, 'h06, lat);
    checks++;
    if ({daa_l_gt_9, daa_h_gt_9, daa_h_eq_9} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL daa_compare: got %b required 100", {daa_l_gt_9, daa_h_gt_9, daa_h_eq_9});
    end
    checks++;
    if ({result, flag_h, flag_c} !== {8'h42, 2'b00}) begin
      errors++;
      $display("[TB] FAIL daa_add: got res=%h h=%b c=%b required res=42 h=0 c=0", result, flag_h, flag_c);
    end
    run_op(T_SUB, 'h10, 'h01, 0, 0, 0, 0, 0, lat);
    checks++;
    if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h0F, 4'b0110}) begin
      errors++;
      $display("[TB] FAIL sub_10_01: got res=%h znhc=%b required res=0f znhc=0110",
               result, {flag_z, flag_n, flag_h, flag_c});
    end
    run_op(T_CP, 'h05, 'h05, 0, 0, 0, 0, 0, lat);
    checks++;
    if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h05, 4'b1100}) begin
      errors++;
      $display("[TB] FAIL cp_05_05: got res=%h znhc=%b required res=05 znhc=1100",
               result, {flag_z, flag_n, flag_h, flag_c});
    end
    run_op(T_ADD, 'h81, 'h00, 1, 0, 1, 0, 0, lat);
    checks++;
    if ({result, flag_z, flag_n, flag_h, flag_c, shift_dbh, shift_dbl} !== {8'h03, 4'b0001, 2'b11}) begin
      errors++;
      $display("[TB] FAIL shift_left: got res=%h znhc=%b dbh/dbl=%b required res=03 znhc=0001 dbh/dbl=11",
               result, {flag_z, flag_n, flag_h, flag_c}, {shift_dbh, shift_dbl});
    end
    run_op(T_ADD, 'h01, 'h00, 0, 1, 0, 0, 0, lat);
    checks++;
    if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h00, 4'b1001}) begin
      errors++;
      $display("[TB] FAIL shift_right: got res=%h znhc=%b required res=00 znhc=1001",
               result, {flag_z, flag_n, flag_h, flag_c});
    end
    m_pc = 1; m_dc = 0;
  endtask

  task automatic test_random();
    int opc, a, b, r, dout, lat;
    bit shl, shr, sin, daa;
    int dtab[4] = '{'h00, 'h06, 'h60, 'h66};
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      opc  = int'($urandom_range(0, 7));
      a    = int'($urandom_range(0, 255));
      b    = int'($urandom_range(0, 255));
      r    = int'($urandom_range(0, 9));
      shl  = (r == 0) || (r == 1);
      shr  = (r == 1) || (r == 2);
      daa  = (r == 3) || (r == 4);
      sin  = ($urandom_range(0, 1) == 1);
      dout = dtab[$urandom_range(0, 3)];
      e = ref_model(opc, a, b, shl, shr, sin, daa, dout, m_pc);
      run_op(opc, a, b, shl, shr, sin, daa, dout, lat);
      checks++;
      if (lat !== LAT) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d required %0d", i, lat, LAT); end
      checks++;
      if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'(e.res), e.z, e.n, e.h, e.c}) begin
        errors++;
        $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h shl=%b shr=%b daa=%b: got res=%h znhc=%b required res=%h znhc=%b",
                 i, opc, a, b, shl, shr, daa, result, {flag_z, flag_n, flag_h, flag_c},
                 8'(e.res), {e.z, e.n, e.h, e.c});
      end
      checks++;
      if ({pri_carry, daa_carry} !== {e.c, e.h}) begin
        errors++;
        $display("[TB] FAIL rand_buffers[%0d]: got %b required %b", i, {pri_carry, daa_carry}, {e.c, e.h});
      end
      checks++;
      if ({shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9} !==
          {a >= 128, (a % 2) == 1, (a % 16) > 9, (a / 16) > 9, (a / 16) == 9}) begin
        errors++;
        $display("[TB] FAIL rand_operand[%0d] a=%h: got %b", i, a,
                 {shift_dbh, shift_dbl, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9});
      end
      m_pc = e.c;
      m_dc = e.h;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(T_ADD, 'hFF, 'h01, 0, 0, 0, 0, 0, lat);
    checks++;
    if ({result, pri_carry} !== {8'h00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got res=%h pc=%b required res=00 pc=1", result, pri_carry);
    end
    run_op(T_ADC, 'h00, 'h00, 0, 0, 0, 0, 0, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d required %0d", lat, LAT); end
    checks++;
    if ({result, flag_z, flag_n, flag_h, flag_c} !== {8'h01, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL b2b_adc: got res=%h znhc=%b required res=01 znhc=0000",
               result, {flag_z, flag_n, flag_h, flag_c});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse: got %b required 0", done); end
    m_pc = 0; m_dc = 0;
  endtask

  task automatic test_busy_ignore();
`ifndef SM83_ALU_FAST_EN
    int extra;
    @(negedge clk);
    op = 3'(T_ADD); a_in = 8'h11; b_in = 8'h22;
    shift_l = 0; shift_r = 0; daa_add = 0;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_high: got %b required 1", busy); end
    @(negedge clk);
    a_in = 8'h50; b_in = 8'h50;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({done, result} !== {1'b1, 8'h33}) begin
      errors++;
      $display("[TB] FAIL busy_first_op: got done=%b res=%h required done=1 res=33", done, result);
    end
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || result !== 8'h33) begin
      errors++;
      $display("[TB] FAIL busy_ignored: got extra dones=%0d res=%h required 0 and 33", extra, result);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    int lat, seen;
    run_op(T_ADD, 'hF0, 'h20, 0, 0, 0, 0, 0, lat);
    checks++;
    if ({result, pri_carry} !== {8'h10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pre_reset_op: got res=%h pc=%b required res=10 pc=1", result, pri_carry);
    end
    @(negedge clk);
    op = 3'(T_ADD); a_in = 8'h01; b_in = 8'h01;
    start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if ({seen != 0, busy, result, pri_carry, daa_carry} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_lo: got dones=%0d busy=%b res=%h pc=%b dc=%b required all 0",
               seen, busy, result, pri_carry, daa_carry);
    end
`ifndef SM83_ALU_FAST_EN
    @(negedge clk);
    a_in = 8'h70; b_in = 8'h70; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({done, busy, result} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_hi: got done=%b busy=%b res=%h required 0", done, busy, result);
    end
    @(negedge clk);
    reset = 1'b0;
`endif
    m_pc = 0; m_dc = 0;
    run_op(T_ADD, 'h12, 'h34, 0, 0, 0, 0, 0, lat);
    checks++;
    if (lat !== LAT || result !== 8'h46) begin
      errors++;
      $display("[TB] FAIL post_reset_op: got lat=%0d res=%h required lat=%0d res=46", lat, result, LAT);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a_in = 8'd0; b_in = 8'd0;
    shift_l = 1'b0; shift_r = 1'b0; shift_into_alu = 1'b0;
    daa_add = 1'b0; daa_out = 8'd0;
    $display("[TB] starting sm83_alu_nibble_core bench");
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
